// File: rtl/imem_ctrl_pkg.sv
// Shared encodings for the instruction-memory controller: FSM states,
// AHB-Lite transfer attributes and the NOP substituted on a bus error.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ITCM     = 2'd1,
        ST_AHB_ADDR = 2'd2,
        ST_AHB_DATA = 2'd3
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

endpackage

// File: rtl/imem_ctrl.sv
// Instruction fetch controller: routes each fetch to the ITCM (1-cycle) or to
// a single-beat AHB-Lite read, returning one instruction per completed access.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  ITCM_BASE   = '0,
    parameter int unsigned            ITCM_AW     = 14
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic [ADDR_WIDTH-1:0]  next_pc,
    output logic                   instr_read_data_valid,
    output logic [INSTR_WIDTH-1:0] instr_read_data,
    output logic                   addr_AHB,
    output logic                   instr_bus_err,
    output logic                   itcm_rd_en,
    output logic [ITCM_AW-1:0]     itcm_addr,
    input  logic [INSTR_WIDTH-1:0] itcm_rd_data,
    output logic [1:0]             htrans,
    output logic [31:0]            haddr,
    output logic                   hwrite,
    output logic [2:0]             hsize,
    output logic [2:0]             hburst,
    input  logic                   hready,
    input  logic                   hresp,
    input  logic [31:0]            hrdata
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:2]   haddr_r;
    logic                    accept;
    logic                    itcm_hit;
    logic                    unused_pc_lsb;

    assign itcm_hit      = (next_pc[ADDR_WIDTH-1:ITCM_AW+2] == ITCM_BASE[ADDR_WIDTH-1:ITCM_AW+2]);
    assign unused_pc_lsb = ^next_pc[1:0];

    assign haddr  = 32'({haddr_r, 2'b00});
    assign hwrite = 1'b0;
    assign hsize  = HSIZE_WORD;
    assign hburst = HBURST_SINGLE;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state   <= ST_IDLE;
            haddr_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !itcm_hit)
                haddr_r <= next_pc[ADDR_WIDTH-1:2];
        end
    end

    always_comb begin
        state_nxt             = state;
        accept                = 1'b0;
        instr_read_data_valid = 1'b0;
        instr_read_data       = '0;
        instr_bus_err         = 1'b0;
        addr_AHB              = 1'b0;
        htrans                = HTRANS_IDLE;
        itcm_rd_en            = 1'b0;
        itcm_addr             = '0;

        // Gating accept with the reset pin keeps every output low while
        // reset is held, even though state already reads IDLE.
        unique case (state)
            ST_IDLE: begin
                accept = cpu_rstn;
            end
            ST_ITCM: begin
                accept                = cpu_rstn;
                instr_read_data_valid = 1'b1;
                instr_read_data       = itcm_rd_data;
                state_nxt             = ST_IDLE;
            end
            ST_AHB_ADDR: begin
                addr_AHB = 1'b1;
                htrans   = HTRANS_NONSEQ;
                if (hready)
                    state_nxt = ST_AHB_DATA;
            end
            ST_AHB_DATA: begin
                addr_AHB        = 1'b1;
                instr_read_data = INSTR_WIDTH'(hrdata);
                if (hready) begin
                    accept                = cpu_rstn;
                    instr_read_data_valid = 1'b1;
                    state_nxt             = ST_IDLE;
                    if (hresp) begin
                        instr_read_data = INSTR_WIDTH'(NOP_INSTR);
                        instr_bus_err   = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (accept) begin
            if (itcm_hit) begin
                itcm_rd_en = 1'b1;
                itcm_addr  = next_pc[ITCM_AW+1:2];
                state_nxt  = ST_ITCM;
            end else begin
                state_nxt  = ST_AHB_ADDR;
            end
        end
    end

endmodule
